// File: rtl/mluart_tx.sv
// -----------------------------------------------------------------------------
// mluart_tx -- UART transmitter, 8 data bits, LSB first, 1 or 2 stop bits.
//
// Transmit-side partner of the team UART receiver. It runs from the same
// 100 MHz clock and the same 16x-baud clock-enable pulse. Each bit lasts
// 16 enable pulses.
//
// Optional feature: define MLUART_TX_PARITY_EN to insert a parity bit between
// data bit 7 and the stop bit(s). ODD_PARITY selects the parity sense. With
// the macro undefined the frame is plain 8-N-1 and no parity logic exists.
//
// Parameters:
//   STOP_BITS   1 or 2 stop bits, each 16 enable pulses long
//   ODD_PARITY  0 = even, 1 = odd (only meaningful with MLUART_TX_PARITY_EN)
//
// Ports:
//   CLK_100MHZ        in   system clock, rising edge
//   reset             in   synchronous, active-high reset
//   clk_en_16_x_baud  in   one-cycle enable pulse at 16x baud
//   write_strobe      in   request to send data_in (one cycle)
//   data_in[7:0]      in   byte to send, sampled only on the accepting cycle
//   UART_TX           out  serial line, idle high, registered
//   tx_busy           out  high whenever the FSM is not idle
//   tx_complete       out  one-cycle pulse after the last stop bit
//   state_dbg_o[3:0]  out  current FSM state encoding, for observation
//
// Handshake: write_strobe is a one-cycle request that is accepted only when
// tx_busy is low in that same cycle. A strobe while tx_busy is high is
// dropped, not queued, and leaves the latched byte untouched. tx_busy rises
// on the cycle after acceptance and falls on the cycle after tx_complete.
// -----------------------------------------------------------------------------
module mluart_tx #(
  parameter int STOP_BITS  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic       CLK_100MHZ,
  input  logic       reset,
  input  logic       clk_en_16_x_baud,
  input  logic       write_strobe,
  input  logic [7:0] data_in,
  output logic       UART_TX,
  output logic       tx_busy,
  output logic       tx_complete,
  output logic [3:0] state_dbg_o
);

  // Elaboration-time guards on the parameter ranges.
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("mluart_tx: STOP_BITS must be 1 or 2");
  end
  if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_odd_parity
    $error("mluart_tx: ODD_PARITY must be 0 or 1");
  end

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_D0     = 4'd2,
    S_D1     = 4'd3,
    S_D2     = 4'd4,
    S_D3     = 4'd5,
    S_D4     = 4'd6,
    S_D5     = 4'd7,
    S_D6     = 4'd8,
    S_D7     = 4'd9,
`ifdef MLUART_TX_PARITY_EN
    S_PARITY = 4'd10,
`endif
    S_STOP   = 4'd11,
    S_DONE   = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       stop_pass_q, stop_pass_d;
  logic       tx_q, tx_d;
`ifdef MLUART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic is_data;
  logic bit_end;

  assign is_data = (state_q inside {S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7});
  // Last enable pulse of the current bit period.
  assign bit_end = clk_en_16_x_baud && (cnt_q == 4'd15);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'd0;
      stop_pass_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef MLUART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      stop_pass_q <= stop_pass_d;
      tx_q        <= tx_d;
`ifdef MLUART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    stop_pass_d = stop_pass_q;
`ifdef MLUART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (write_strobe) begin
          shift_d     = data_in;
          cnt_d       = 4'd0;
          stop_pass_d = 1'b0;
`ifdef MLUART_TX_PARITY_EN
          parity_d    = (^data_in) ^ (ODD_PARITY != 0);
`endif
          state_d     = S_START;
        end
      end

      // tdone is exactly one clock, independent of the enable.
      S_DONE: state_d = S_IDLE;

      // Every other state times a bit on the enable pulses. Unused encodings
      // also land here and fall back to idle at the next bit boundary.
      default: begin
        if (clk_en_16_x_baud) cnt_d = cnt_q + 4'd1;

        // The byte is shifted out LSB first; bit 0 of the register is always
        // the bit currently on the line.
        if (bit_end && is_data) shift_d = {1'b0, shift_q[7:1]};

        if (bit_end) begin
          case (state_q)
            S_START:  state_d = S_D0;
            S_D0:     state_d = S_D1;
            S_D1:     state_d = S_D2;
            S_D2:     state_d = S_D3;
            S_D3:     state_d = S_D4;
            S_D4:     state_d = S_D5;
            S_D5:     state_d = S_D6;
            S_D6:     state_d = S_D7;
`ifdef MLUART_TX_PARITY_EN
            S_D7:     state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
`else
            S_D7:     state_d = S_STOP;
`endif
            S_STOP: begin
              // Two stop bits: first pass through the counter sets the flag
              // and stays in tstop; the second pass finishes the frame.
              if (STOP_BITS == 2 && !stop_pass_q) begin
                stop_pass_d = 1'b1;
              end else begin
                stop_pass_d = 1'b0;
                state_d     = S_DONE;
              end
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line value, one clock behind the state that selects it.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d = 1'b1;
    if (state_q == S_START) begin
      tx_d = 1'b0;
    end else if (is_data) begin
      tx_d = shift_q[0];
`ifdef MLUART_TX_PARITY_EN
    end else if (state_q == S_PARITY) begin
      tx_d = parity_q;
`endif
    end
  end

  assign UART_TX     = tx_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_complete = (state_q == S_DONE);
  assign state_dbg_o = state_q;

endmodule
